int_ctrl: RTL

Interrupt controller on the requesting side of the CPU interrupt interface. It collects edge-triggered requests from peripheral lines and masks them. It picks the highest-priority pending source and presents it to the control unit as a request flag (feeds FR bit 2) plus an 8-bit vector (feeds the data path to PC). It holds that request until the control unit acknowledges the vector jump, then tracks the source as in-service until end-of-interrupt.

---
 rtl/int_ctrl_pkg.sv | 30 +++
 rtl/int_ctrl_prio_enc.sv | 29 ++
 rtl/int_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/int_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// int_ctrl_pkg
// Shared definitions for the interrupt controller slice:
//   - FSM state encoding (IDLE / REQ / GUARD)
//   - maximum number of request lines and matching index width
//   - vector width and the vector address helper
// No ports (package).
// -----------------------------------------------------------------------------
package int_ctrl_pkg;

    localparam int MAX_IRQ = 8;
    localparam int IDX_W   = 3;
    localparam int VEC_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    // Vector address of source idx; arithmetic wraps silently at 8 bits.
    function automatic logic [VEC_W-1:0] vec_addr(
        input logic [VEC_W-1:0] base,
        input logic [VEC_W-1:0] stride,
        input logic [IDX_W-1:0] idx
    );
        vec_addr = base + (VEC_W'(idx) * stride);
    endfunction

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Combinational lowest-index-first priority encoder.
// Ports:
//   req   in  N      request vector, bit 0 is highest priority
//   valid out 1      at least one request bit set
//   idx   out IDX_W  index of the lowest set bit (0 when valid is low)
// -----------------------------------------------------------------------------
module irq_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]     req,
    output logic             valid,
    output logic [IDX_W-1:0] idx
);

    // Scan from the top down so the lowest set index is written last.
    always_comb begin
        valid = 1'b0;
        idx   = {IDX_W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            idx   = req[i] ? IDX_W'(i) : idx;
            valid = valid | req[i];
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt controller: edge-detects peripheral request lines, masks them,
// picks the highest-priority pending source and presents it to the control
// unit as int_req (FR[2]) plus an 8-bit vector. The request is held until
// int_ack, followed by one guard cycle; the source is then in service until
// eoi.
// Optional feature: define INT_CTRL_NEST_EN to let a higher-priority source
// preempt a running handler; otherwise requests wait until in_service is 0.
// Ports:
//   clock       in   1        system clock, rising edge
//   reset       in   1        synchronous active-high reset
//   irq         in   NUM_IRQ  request lines (synchronous)
//   mask_w      in   1        mask register write strobe
//   mask_data   in   NUM_IRQ  new mask value, 1 = masked
//   int_ack     in   1        control unit took the vector
//   eoi         in   1        end-of-interrupt pulse
//   int_req     out  1        interrupt request (FR[2])
//   int_vector  out  8        vector address of requested source
//   pending     out  NUM_IRQ  pending register
//   in_service  out  NUM_IRQ  in-service register
// -----------------------------------------------------------------------------
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int               NUM_IRQ    = 4,
    parameter logic [VEC_W-1:0] VEC_BASE   = 8'h10,
    parameter logic [VEC_W-1:0] VEC_STRIDE = 8'h08
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               mask_w,
    input  logic [NUM_IRQ-1:0] mask_data,
    input  logic               int_ack,
    input  logic               eoi,
    output logic               int_req,
    output logic [VEC_W-1:0]   int_vector,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] in_service
);

    localparam logic [NUM_IRQ-1:0] ZERO_V = {NUM_IRQ{1'b0}};

    state_t             state_r, state_n;
    logic [IDX_W-1:0]   idx_r, idx_n;
    logic [NUM_IRQ-1:0] mask_r, irq_prev_r;
    logic               req_n;
    logic [VEC_W-1:0]   vec_n;

    logic [NUM_IRQ-1:0] rise_s, allow_s, cand_req_s;
    logic [NUM_IRQ-1:0] latched_oh_s, ack_oh_s, eoi_oh_s;
    logic               cand_valid_s, isr_valid_s, ack_fire_s;
    logic [IDX_W-1:0]   cand_idx_s, isr_idx_s;

    function automatic logic [NUM_IRQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        for (int i = 0; i < NUM_IRQ; i++) begin
            onehot[i] = (idx == IDX_W'(i));
        end
    endfunction

    assign rise_s       = irq & ~irq_prev_r;
    assign latched_oh_s = onehot(idx_r);

    // Lowest in-service index: eoi target and nesting threshold.
    irq_prio_enc #(.N(NUM_IRQ)) u_isr_enc (
        .req   (in_service),
        .valid (isr_valid_s),
        .idx   (isr_idx_s)
    );

    // Which sources the in-service state currently allows to request.
    always_comb begin
`ifdef INT_CTRL_NEST_EN
        for (int i = 0; i < NUM_IRQ; i++) begin
            allow_s[i] = !isr_valid_s || (IDX_W'(i) < isr_idx_s);
        end
`else
        allow_s = {NUM_IRQ{!isr_valid_s}};
`endif
    end

    assign cand_req_s = pending & ~mask_r & allow_s;

    irq_prio_enc #(.N(NUM_IRQ)) u_cand_enc (
        .req   (cand_req_s),
        .valid (cand_valid_s),
        .idx   (cand_idx_s)
    );

    // Next-state and next-output logic of the request FSM.
    always_comb begin
        state_n    = state_r;
        idx_n      = idx_r;
        req_n      = 1'b0;
        vec_n      = int_vector;
        ack_fire_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cand_valid_s) begin
                    state_n = ST_REQ;
                    idx_n   = cand_idx_s;
                    req_n   = 1'b1;
                    vec_n   = vec_addr(VEC_BASE, VEC_STRIDE, cand_idx_s);
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_REQ: begin
                // Ack beats a same-cycle mask write: withdraw looks at the
                // mask as it stood before this edge.
                if (int_ack) begin
                    ack_fire_s = 1'b1;
                    state_n    = ST_GUARD;
                end else if (|(latched_oh_s & (mask_r | ~pending))) begin
                    state_n = ST_IDLE;
                end else begin
                    req_n = 1'b1;
                end
            end
            ST_GUARD: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    assign ack_oh_s = ack_fire_s ? latched_oh_s : ZERO_V;
    assign eoi_oh_s = (eoi && isr_valid_s) ? onehot(isr_idx_s) : ZERO_V;

    // FSM state and registered request outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= {IDX_W{1'b0}};
            int_req    <= 1'b0;
            int_vector <= VEC_BASE;
        end else begin
            state_r    <= state_n;
            idx_r      <= idx_n;
            int_req    <= req_n;
            int_vector <= vec_n;
        end
    end

    // Pending / in-service / mask / edge history; a new edge beats the ack
    // clear, and eoi acts on the in-service value before the ack bit is set.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending    <= ZERO_V;
            in_service <= ZERO_V;
            mask_r     <= {NUM_IRQ{1'b1}};
            irq_prev_r <= ZERO_V;
        end else begin
            pending    <= (pending & ~ack_oh_s) | rise_s;
            in_service <= (in_service & ~eoi_oh_s) | ack_oh_s;
            mask_r     <= mask_w ? mask_data : mask_r;
            irq_prev_r <= irq;
        end
    end

endmodule
